// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus bundle of the direct-mapped write-back data cache.
// Handshake: a CPU request is held while cpu_stall_o=1 and completes in the first cycle with
// cpu_stall_o=0. mem_req_o plus its we/addr/wdata stay unchanged until the cycle where the
// single-cycle mem_ack_i pulse is sampled high.
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: 32 lines of 8 words.
// Hits finish in the request cycle; misses stall through WRITEBACK/ALLOCATE/UPDATE.
module dcache_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_ctrl_if.slave       bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;

    state_e state_q, state_d;

    logic         valid_q [32];
    logic         dirty_q [32];
    logic [21:0]  tag_q   [32];
    logic [255:0] data_q  [32];

    logic [21:0]  cpu_tag;
    logic [4:0]   idx;
    logic [2:0]   off;
    logic [7:0]   bit_base;
    logic         hit;
    logic         store_hit;
    logic         fill;
    logic         unused_addr_bits;

    assign cpu_tag          = bus.cpu_addr_i[31:10];
    assign idx              = bus.cpu_addr_i[9:5];
    assign off              = bus.cpu_addr_i[4:2];
    assign bit_base         = {off, 5'b0};
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign hit       = bus.cpu_req_i & valid_q[idx] & (tag_q[idx] == cpu_tag);
    assign store_hit = (state_q == IDLE) & hit & bus.cpu_we_i;
    assign fill      = (state_q == ALLOCATE) & bus.mem_ack_i;

    assign dbg_state_o = state_q;

    always_comb begin
        state_d         = state_q;
        bus.cpu_rdata_o = 32'h0;
        bus.cpu_stall_o = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 256'h0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        if (!bus.cpu_we_i) bus.cpu_rdata_o = data_q[idx][bit_base +: 32];
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.cpu_stall_o = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = {tag_q[idx], idx, 5'b0};
                bus.mem_wdata_o = data_q[idx];
                if (bus.mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                bus.cpu_stall_o = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_addr_o  = {cpu_tag, idx, 5'b0};
                if (bus.mem_ack_i) state_d = UPDATE;
            end
            UPDATE: begin
                // Refilled line is in place; IDLE re-evaluates the held request as a hit.
                bus.cpu_stall_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            for (int i = 0; i < 32; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= 22'h0;
                data_q[i]  <= 256'h0;
            end
        end else begin
            state_q <= state_d;
            if (store_hit) begin
                data_q[idx][bit_base +: 32] <= bus.cpu_wdata_i;
                dirty_q[idx] <= 1'b1;
            end
            if (fill) begin
                data_q[idx]  <= bus.mem_rdata_i;
                tag_q[idx]   <= cpu_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then randomized accesses
// checked against a line/memory-level reference model and a memory transaction scoreboard.
module tb_dcache_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [288:0] obs, input logic [288:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory image seen by the responder (written by DUT) and by the model (written by model)
  logic [255:0] bus_mem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  function automatic logic [255:0] default_block(input logic [31:0] a);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = a ^ (32'(w) << 24) ^ 32'h5A5A_0013;
    return b;
  endfunction

  function automatic logic [255:0] bus_block(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return default_block(a);
  endfunction

  function automatic logic [255:0] ref_block(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_block(a);
  endfunction

  // memory responder
  typedef struct {
    logic [288:0] pkt;   // {we, addr, wdata}
    int           cyc;
    logic         stable;
  } txn_t;
  txn_t obs_q[$];

  int           ack_lat  = 0;
  bit           rand_lat = 0;
  int           cnt      = 0;
  int           cur_lat  = 0;
  logic [288:0] start_pkt;

  always @(negedge clk) begin
    txn_t t;
    logic [288:0] now_pkt;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 256'h0;
    now_pkt = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
    if (!bus.mem_req_o) begin
      cnt = 0;
    end else begin
      if (cnt == 0) begin
        start_pkt = now_pkt;
        cur_lat   = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
      end
      if (cnt == cur_lat) begin
        bus.mem_ack_i = 1'b1;
        if (bus.mem_we_o) bus_mem[bus.mem_addr_o] = bus.mem_wdata_o;
        else bus.mem_rdata_i = bus_block(bus.mem_addr_o);
        t.pkt    = now_pkt;
        t.cyc    = cur_lat + 1;
        t.stable = (now_pkt === start_pkt);
        obs_q.push_back(t);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // reference model: cache contents at line granularity
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [288:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 22'h0;
      m_data[i]  = 256'h0;
    end
  endtask

  // driver: one CPU access, held until the stall clears; checks the completing cycle
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output logic [31:0] rd);
    int          li, wo, exp_cyc;
    logic [21:0] tg;
    logic        miss;
    logic [31:0] exp_rd;
    li = int'(addr[9:5]);
    wo = int'(addr[4:2]);
    tg = addr[31:10];
    exp_q.delete();
    miss = !(m_valid[li] && m_tag[li] == tg);
    if (miss) begin
      if (m_valid[li] && m_dirty[li]) begin
        exp_q.push_back({1'b1, m_tag[li], 5'(li), 5'b0, m_data[li]});
        ref_mem[{m_tag[li], 5'(li), 5'b0}] = m_data[li];
      end
      exp_q.push_back({1'b0, tg, 5'(li), 5'b0, 256'h0});
      m_data[li]  = ref_block({tg, 5'(li), 5'b0});
      m_valid[li] = 1'b1;
      m_dirty[li] = 1'b0;
      m_tag[li]   = tg;
    end
    exp_rd = we ? 32'h0 : m_data[li][32*wo +: 32];
    if (we) begin
      m_data[li][32*wo +: 32] = wdata;
      m_dirty[li] = 1'b1;
    end

    @(negedge clk);
    obs_q.delete();
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    #1;
    cyc = 0;
    while (bus.cpu_stall_o === 1'b1 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) check_val("stall_timeout", 289'(cyc), 289'(0));
    rd = bus.cpu_rdata_o;
    check_val("rdata", 289'(rd), 289'(exp_rd));
    check_val("hit_mem_req", 289'(bus.mem_req_o), 289'(0));
    check_val("hit_mem_bus", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, 289'(0));
    check_val("txn_count", 289'(obs_q.size()), 289'(exp_q.size()));
    exp_cyc = miss ? 2 : 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      exp_cyc += obs_q[i].cyc;
      check_val("txn_stable", 289'(obs_q[i].stable), 289'(1));
      if (i < exp_q.size()) check_val("txn", obs_q[i].pkt, exp_q[i]);
    end
    check_val("stall_cycles", 289'(cyc), 289'(exp_cyc));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    #1;
    check_val("idle_stall", 289'(bus.cpu_stall_o), 289'(0));
    check_val("idle_rdata", 289'(bus.cpu_rdata_o), 289'(0));
    check_val("idle_mem", {bus.mem_req_o, bus.mem_addr_o, bus.mem_wdata_o[255:1]}, 289'(0));
  endtask

  logic [255:0] blk;
  logic [31:0]  rd;
  int           cyc;
  int           waited;

  initial begin
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = 32'h0;
    bus.cpu_wdata_i = 32'h0;
    rst = 1'b1;
    model_reset();
    blk = default_block(32'h400);
    blk[63:32] = 32'hDEAD_BEEF;
    bus_mem[32'h400] = blk;
    ref_mem[32'h400] = blk;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_state", 289'(dbg_state), 289'(0));
    check_val("rst_stall", 289'(bus.cpu_stall_o), 289'(0));
    check_val("rst_rdata", 289'(bus.cpu_rdata_o), 289'(0));
    check_val("rst_mem_req", 289'(bus.mem_req_o), 289'(0));
    check_val("rst_mem_bus", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, 289'(0));

    // cold load, allocate acked after 3 cycles
    ack_lat = 2;
    access(1'b0, 32'h0000_0404, 32'h0, cyc, rd);
    check_val("cold_rdata", 289'(rd), 289'(32'hDEAD_BEEF));
    check_val("cold_stall", 289'(cyc), 289'(5));
    if (obs_q.size() == 1) check_val("cold_addr", 289'(obs_q[0].pkt[287:256]), 289'(32'h400));
    else check_val("cold_txns", 289'(obs_q.size()), 289'(1));

    // store hit then reads
    access(1'b1, 32'h0000_0408, 32'h1234_5678, cyc, rd);
    check_val("store_hit_stall", 289'(cyc), 289'(0));
    access(1'b0, 32'h0000_0408, 32'h0, cyc, rd);
    check_val("store_readback", 289'(rd), 289'(32'h1234_5678));
    access(1'b0, 32'h0000_0404, 32'h0, cyc, rd);
    check_val("neighbour_word", 289'(rd), 289'(32'hDEAD_BEEF));

    // dirty eviction
    access(1'b0, 32'h0000_0804, 32'h0, cyc, rd);
    check_val("evict_stall", 289'(cyc), 289'(8));
    if (obs_q.size() == 2) begin
      check_val("wb_addr", 289'(obs_q[0].pkt[287:256]), 289'(32'h400));
      check_val("wb_we", 289'(obs_q[0].pkt[288]), 289'(1));
      check_val("wb_word2", 289'(obs_q[0].pkt[95:64]), 289'(32'h1234_5678));
      check_val("wb_word1", 289'(obs_q[0].pkt[63:32]), 289'(32'hDEAD_BEEF));
      check_val("alloc_addr", 289'(obs_q[1].pkt[287:256]), 289'(32'h800));
    end else check_val("evict_txns", 289'(obs_q.size()), 289'(2));

    // clean eviction: straight to allocate
    access(1'b0, 32'h0000_0C04, 32'h0, cyc, rd);
    check_val("clean_txns", 289'(obs_q.size()), 289'(1));
    if (obs_q.size() >= 1) check_val("clean_addr", 289'(obs_q[0].pkt[287:256]), 289'(32'hC00));

    // back-to-back hits over a resident line
    for (int w = 0; w < 8; w++) begin
      access(1'b0, 32'h0000_0C00 + 32'(4 * w), 32'h0, cyc, rd);
      check_val("b2b_stall", 289'(cyc), 289'(0));
    end
    idle_cycle();

    // reset while allocating
    ack_lat = 6;
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_1404;
    waited = 0;
    #1;
    while (!(bus.mem_req_o === 1'b1 && bus.mem_we_o === 1'b0) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check_val("mid_alloc_seen", 289'(waited < 20), 289'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req_i = 1'b0;
    #1;
    check_val("midrst_mem_req", 289'(bus.mem_req_o), 289'(0));
    check_val("midrst_state", 289'(dbg_state), 289'(0));
    check_val("midrst_stall", 289'(bus.cpu_stall_o), 289'(0));
    model_reset();
    ack_lat = 1;
    access(1'b0, 32'h0000_1404, 32'h0, cyc, rd);
    check_val("reload_stall", 289'(cyc), 289'(4));

    // randomized traffic over a few conflicting tags and indices
    rand_lat = 1;
    for (int n = 0; n < 400; n++) begin
      logic [21:0] tg;
      logic [4:0]  ix;
      logic [2:0]  of;
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        tg = 22'($urandom_range(0, 5));
        ix = 5'($urandom_range(0, 3));
        of = 3'($urandom_range(0, 7));
        access(1'($urandom_range(0, 1)), {tg, ix, of, 2'b00}, $urandom, cyc, rd);
      end
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters: 32 lines, 32-byte blocks (8 words), direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL provide these ports, one clock, synchronous active-high reset:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cpu_req_i  in  1  MEM-stage load/store request valid
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word-aligned
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data
- cpu_stall_o  out  1  freeze pipeline (PC, IFID, IDEX, EXMEM, MEMWB hold)
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  1 = block write, 0 = block read
- mem_addr_o  out  32  block address, bits [4:0] = 0
- mem_wdata_o  out  256  victim block data
- mem_rdata_i  in  256  refill block data
- mem_ack_i  in  1  memory transaction complete, single-cycle pulse

Function
REQ-003 Address split SHALL be tag = addr[31:10] (22 b), index = addr[9:5], word offset = addr[4:2]; addr[1:0] ignored.
REQ-004 Each line SHALL hold valid bit, dirty bit, 22-bit tag, 256-bit data; word w occupies data[32w+31:32w].
REQ-005 Hit SHALL be cpu_req_i & valid[index] & (tag[index] == addr tag), evaluated combinationally.
REQ-006 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-007 In IDLE with cpu_req_i=0: cpu_stall_o=0, no state change.
REQ-008 In IDLE on hit: cpu_stall_o=0 same cycle; load: cpu_rdata_o = addressed word combinationally; store: addressed word written and dirty set at that clock edge, other 7 words unchanged.
REQ-009 In IDLE on miss: cpu_stall_o=1 combinationally same cycle; next state WRITEBACK if victim valid & dirty, else ALLOCATE.
REQ-010 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o = victim data; on mem_ack_i go to ALLOCATE.
REQ-011 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i capture mem_rdata_i into line, set tag, valid=1, dirty=0, go to UPDATE.
REQ-012 UPDATE: mem_req_o=0, cpu_stall_o=1 for one cycle, then IDLE, where the access re-evaluates as a hit and completes per REQ-008.
REQ-013 cpu_stall_o SHALL be 1 in WRITEBACK, ALLOCATE, UPDATE, and IDLE-miss; miss latency = 1 + (WB cycles) + (alloc cycles) + 1 before the hit cycle.
REQ-014 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o SHALL be stable while mem_req_o=1 until the ack cycle; mem_req_o SHALL drop the cycle after mem_ack_i unless the next state requests again (WRITEBACK->ALLOCATE keeps mem_req_o=1 with new address/we).
REQ-015 mem_ack_i SHALL be ignored in IDLE and UPDATE.
REQ-016 cpu_req_i/cpu_addr_i are held by the stalled pipeline; a change during a miss is not supported, and the FSM SHALL complete the started transaction regardless.
REQ-017 Outside IDLE-hit loads, cpu_rdata_o SHALL be 0.
REQ-018 Outside WRITEBACK/ALLOCATE, mem_we_o, mem_addr_o, mem_wdata_o SHALL be 0.

Reset
REQ-019 When rst_i=1 at a clock edge: state=IDLE, all valid, dirty, tag, and data cleared to 0; rst_i SHALL override every other input in that cycle.
REQ-020 Reset values of outputs SHALL be cpu_rdata_o=0, cpu_stall_o=0 (absent request), mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-021 Reset during WRITEBACK/ALLOCATE SHALL abandon the transaction; mem_req_o=0 the cycle after the reset edge; dirty data is lost.

Verification
REQ-022 Cold load: reset, load 0x0000_0404 (idx 0, off 1), ack after 3 cycles with word1=0xDEAD_BEEF -> mem_addr_o=0x400, mem_we_o=0, stall 1+3+1 cycles, then rdata=0xDEADBEEF, stall=0.
REQ-023 Store hit: after REQ-022, store 0x1234_5678 to 0x408 -> stall=0, next load 0x408 returns 0x12345678, 0x404 still 0xDEADBEEF.
REQ-024 Dirty eviction: then load 0x0000_0804 (same index, tag 2) -> WRITEBACK to 0x400 with mem_wdata_o[95:64]=0x12345678 and [63:32]=0xDEADBEEF, then ALLOCATE 0x800, then hit.
REQ-025 Clean eviction: load 0x0C04 after REQ-024 -> no WRITEBACK, ALLOCATE 0xC00 directly.
REQ-026 Reset mid-miss: assert rst_i during ALLOCATE -> mem_req_o=0 next cycle, state IDLE, reload of same address misses again.
REQ-027 Back-to-back hits: 8 consecutive loads of words 0..7 of a resident line -> stall=0 every cycle, correct words each cycle.
